cla_pipe_adder: RTL and testbench
=================================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have derived localparam NG = WIDTH/4, the number of 4-bit lookahead groups and pipeline stages.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set present on A/B/c_in/sub.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 B  input  WIDTH  operand B.
REQ-010 c_in  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  0 = A+B+c_in; 1 = A-B, i.e. A+~B+1.
REQ-012 out_valid  output  1  result present on sum/c_out/ovf.
REQ-013 out_ready  input  1  downstream accepts result this cycle.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-016 ovf  output  1  signed overflow of the result.

Function
REQ-017 Each stage k (0..NG-1) SHALL compute result bits [4k+3:4k] with a 4-bit carry-lookahead group: generate/propagate per bit, all group carries from g/p and the group carry-in; no ripple within a group.
REQ-018 Group k carry-in SHALL come from the stage k-1 registered carry; group 0 carry-in = sub ? 1 : c_in.
REQ-019 Each stage SHALL register its group sum, group carry-out, a valid bit, and the not-yet-consumed upper operand bits (B pre-inverted when sub=1), so the pipe is WIDTH-skewed and carries one operation per stage.
REQ-020 Already-computed low result bits SHALL travel with their operation so that all WIDTH bits of sum appear together.
REQ-021 Latency SHALL be NG cycles: an operand set accepted on edge t yields out_valid=1 with its result after edge t+NG-1, i.e. visible in cycle t+NG-1 following acceptance, when no stall occurs.
REQ-022 Throughput SHALL be one operation per cycle with no bubbles inserted by the block.
REQ-023 advance = ~out_valid | out_ready; in_ready SHALL equal advance combinationally.
REQ-024 A transfer in SHALL occur iff in_valid & in_ready; a transfer out iff out_valid & out_ready.
REQ-025 When advance=0 all stages SHALL hold; sum/c_out/ovf/out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 When advance=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-027 Results SHALL leave in acceptance order; no operation is dropped or duplicated.
REQ-028 c_out SHALL be the carry out of bit WIDTH-1; ovf = carry into MSB XOR carry out of MSB.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; sum/c_out/ovf SHALL be don't-care when out_valid=0, but must not be X after reset.

Reset
REQ-030 rst=1 at a rising edge SHALL clear every stage valid bit, so out_valid=0 in the next cycle; data registers SHALL be cleared to 0.
REQ-031 During rst=1, in_ready SHALL be 1 and in_valid SHALL be ignored; no operation is accepted on a reset edge.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none emerge afterwards.

Verification (WIDTH=16 unless noted; out_ready=1 unless noted)
REQ-033 Accept A=0xFFFF B=0x0001 c_in=0 sub=0 -> 4 cycles later sum=0x0000, c_out=1, ovf=0.
REQ-034 Accept A=0x7FFF B=0x0001 c_in=0 sub=0 -> sum=0x8000, c_out=0, ovf=1; then A=0x0005 B=0x0007 sub=1 -> sum=0xFFFE, c_out=0, ovf=0, in the next output cycle.
REQ-035 Back-to-back A=0x00AA B=0x00CC c_in=1, A=0x0099 B=0x00AA c_in=1, A=0x8000 B=0x8000 c_in=0 -> consecutive outputs 0x0177/0,0; 0x0144/0,0; 0x0000/c_out=1,ovf=1.
REQ-036 Fill with 5 operations, hold out_ready=0 for 6 cycles -> in_ready=0 after the pipe fills, output held stable; release -> all 5 results in order, no gaps.
REQ-037 Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 in the next cycle and no stale results ever appear; a new operation then has normal NG latency.
REQ-038 WIDTH=4, A=0xA B=0xC c_in=1 -> 1-cycle latency, sum=0x7, c_out=1, ovf=1.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit group per stage.
// Operands are skewed through the pipe; results emerge NG cycles after acceptance.
module cla_pipe_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NG = WIDTH / 4;

   // Returns {carry out, carry into bit 3, 4-bit sum}.
   function automatic logic [5:0] cla4(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       ci
   );
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], c[3], p ^ c[3:0]};
   endfunction

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = rst | advance;
   assign b_eff    = sub ? ~B : B;
   assign c0       = sub | c_in;

   for (genvar k = 0; k < NG; k++) begin : g_stg
      logic [WIDTH-1:4*k] ain;
      logic [WIDTH-1:4*k] bin;
      logic               gci;
      logic               gvld;
      logic [5:0]         r;
      logic               vld;
      logic               cy;
      logic [4*k+3:0]     s;

      assign r = cla4(ain[4*k+3:4*k], bin[4*k+3:4*k], gci);

      if (k == 0) begin : g_src
         assign ain  = A;
         assign bin  = b_eff;
         assign gci  = c0;
         assign gvld = in_valid;

         always_ff @(posedge clk) begin
            if (rst) s <= '0;
            else if (advance) s <= r[3:0];
         end
      end else begin : g_src
         assign ain  = g_stg[k-1].g_up.a;
         assign bin  = g_stg[k-1].g_up.b;
         assign gci  = g_stg[k-1].cy;
         assign gvld = g_stg[k-1].vld;

         // Low result bits ride along with their operation.
         always_ff @(posedge clk) begin
            if (rst) s <= '0;
            else if (advance) s <= {r[3:0], g_stg[k-1].s};
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld <= 1'b0;
            cy  <= 1'b0;
         end else if (advance) begin
            vld <= gvld;
            cy  <= r[5];
         end
      end

      if (k < NG-1) begin : g_up
         logic [WIDTH-1:4*k+4] a;
         logic [WIDTH-1:4*k+4] b;

         always_ff @(posedge clk) begin
            if (rst) begin
               a <= '0;
               b <= '0;
            end else if (advance) begin
               a <= ain[WIDTH-1:4*k+4];
               b <= bin[WIDTH-1:4*k+4];
            end
         end
      end

      if (k == NG-1) begin : g_last
         logic ovf_q;

         always_ff @(posedge clk) begin
            if (rst) ovf_q <= 1'b0;
            else if (advance) ovf_q <= r[5] ^ r[4];
         end
      end
   end

   assign out_valid = g_stg[NG-1].vld;
   assign sum       = g_stg[NG-1].s;
   assign c_out     = g_stg[NG-1].cy;
   assign ovf       = g_stg[NG-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: 16-bit pipe plus a 4-bit instance.
// Expected results are hand-computed constants consumed in order.
module tb_cla_pipe_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] A, B, sum;
   logic        c_in, sub, c_out, ovf;

   logic        in4_valid, in4_ready, out4_valid, out4_ready;
   logic [3:0]  a4, b4, sum4;
   logic        c4_in, sub4, c4_out, ovf4;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
   } res_t;

   res_t exq[$];

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   cla_pipe_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in4_valid), .in_ready(in4_ready),
      .A(a4), .B(b4), .c_in(c4_in), .sub(sub4),
      .out_valid(out4_valid), .out_ready(out4_ready),
      .sum(sum4), .c_out(c4_out), .ovf(ovf4)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input logic [15:0] s, input logic c,
                             input logic v);
      res_t e;
      e.s = s;
      e.c = c;
      e.v = v;
      exq.push_back(e);
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb);
      int n;
      A        = a;
      B        = b;
      c_in     = ci;
      sub      = sb;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 50) begin
         cyc();
         n++;
      end
      if (n == 50) chk("in_ready_timeout", 0, 1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exq.size() != 0 || out_valid) && n < 100) begin
         cyc();
         n++;
      end
      if (n == 100) chk("drain_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      res_t e;
      if (!rst && out_valid && out_ready) begin
         if (exq.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = exq.pop_front();
            chk("sum", sum, e.s);
            chk("c_out", c_out, e.c);
            chk("ovf", ovf, e.v);
         end
      end
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      A          = '0;
      B          = '0;
      c_in       = 1'b0;
      sub        = 1'b0;
      in4_valid  = 1'b0;
      out4_ready = 1'b1;
      a4         = '0;
      b4         = '0;
      c4_in      = 1'b0;
      sub4       = 1'b0;

      cyc();
      A        = 16'h1234;
      B        = 16'h1111;
      in_valid = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      cyc();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 16'h0000);
      chk("rst_c_out", c_out, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_out4_valid", out4_valid, 0);

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) cyc();
      chk("rst_ignored_op", out_valid, 0);

      // FFFF + 1 wraps with carry, no signed overflow.
      expect_res(16'h0000, 1'b1, 1'b0);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) begin
         chk("latency", out_valid, (j == 3));
         if (j < 3) cyc();
      end
      chk("wrap_sum", sum, 16'h0000);
      wait_idle();

      expect_res(16'h8000, 1'b0, 1'b1);
      expect_res(16'hFFFE, 1'b0, 1'b0);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      cyc();
      cyc();
      chk("ovf_sum", sum, 16'h8000);
      cyc();
      chk("sub_valid", out_valid, 1);
      chk("sub_sum", sum, 16'hFFFE);
      wait_idle();

      expect_res(16'h0177, 1'b0, 1'b0);
      expect_res(16'h0144, 1'b0, 1'b0);
      expect_res(16'h0000, 1'b1, 1'b1);
      issue(16'h00AA, 16'h00CC, 1'b1, 1'b0);
      issue(16'h0099, 16'h00AA, 1'b1, 1'b0);
      issue(16'h8000, 16'h8000, 1'b0, 1'b0);
      cyc();
      for (int j = 0; j < 3; j++) begin
         chk("b2b_valid", out_valid, 1);
         cyc();
      end
      wait_idle();

      // Fill the pipe while downstream is stalled.
      out_ready = 1'b0;
      expect_res(16'h1212, 1'b0, 1'b0);
      expect_res(16'h2323, 1'b0, 1'b0);
      expect_res(16'h3434, 1'b0, 1'b0);
      expect_res(16'h4545, 1'b0, 1'b0);
      expect_res(16'h5656, 1'b0, 1'b0);
      issue(16'h1111, 16'h0101, 1'b0, 1'b0);
      issue(16'h2222, 16'h0101, 1'b0, 1'b0);
      issue(16'h3333, 16'h0101, 1'b0, 1'b0);
      issue(16'h4444, 16'h0101, 1'b0, 1'b0);
      A        = 16'h5555;
      B        = 16'h0101;
      in_valid = 1'b1;
      for (int h = 0; h < 6; h++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_sum", sum, 16'h1212);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("release_no_gap", out_valid, 1);
         cyc();
      end
      chk("release_done", out_valid, 0);
      wait_idle();

      // Reset with three operations in flight discards them all.
      issue(16'h0101, 16'h0101, 1'b0, 1'b0);
      issue(16'h0202, 16'h0202, 1'b0, 1'b0);
      issue(16'h0303, 16'h0303, 1'b0, 1'b0);
      A        = 16'h0404;
      B        = 16'h0404;
      in_valid = 1'b1;
      rst      = 1'b1;
      cyc();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("midrst_valid", out_valid, 0);
      repeat (8) cyc();
      chk("midrst_no_stale", out_valid, 0);

      expect_res(16'h0579, 1'b0, 1'b0);
      issue(16'h0123, 16'h0456, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) begin
         chk("post_rst_latency", out_valid, (j == 3));
         if (j < 3) cyc();
      end
      wait_idle();

      // 4-bit instance: single-stage pipe.
      a4        = 4'hA;
      b4        = 4'hC;
      c4_in     = 1'b1;
      sub4      = 1'b0;
      in4_valid = 1'b1;
      cyc();
      in4_valid = 1'b0;
      chk("w4_valid", out4_valid, 1);
      chk("w4_sum", sum4, 4'h7);
      chk("w4_c_out", c4_out, 1);
      chk("w4_ovf", ovf4, 1);

      a4        = 4'h3;
      b4        = 4'h4;
      c4_in     = 1'b0;
      sub4      = 1'b1;
      in4_valid = 1'b1;
      cyc();
      in4_valid = 1'b0;
      chk("w4_sub_sum", sum4, 4'hF);
      chk("w4_sub_c_out", c4_out, 0);
      chk("w4_sub_ovf", ovf4, 0);
      cyc();
      chk("w4_idle", out4_valid, 0);

      chk("queue_drained", exq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
